// File: rtl/leaderboard_tracker_if.sv
// Update handshake between the game round logic and the leaderboard tracker.
// The round logic is the master; the tracker is the slave.
interface leaderboard_tracker_if #(
  parameter int ID_W    = 3,
  parameter int SCORE_W = 4
) ();
  logic               upd_valid;
  logic [ID_W-1:0]    upd_id;
  logic [SCORE_W-1:0] upd_score;
  logic               upd_ready;
  logic               upd_done;
  logic               upd_err;
  logic               new_best;
  logic               new_max;

  modport master (
    output upd_valid, upd_id, upd_score,
    input  upd_ready, upd_done, upd_err, new_best, new_max
  );

  modport slave (
    input  upd_valid, upd_id, upd_score,
    output upd_ready, upd_done, upd_err, new_best, new_max
  );
endinterface

// File: rtl/leaderboard_tracker.sv
// Per-player score table with a running global leader. The table is cleared by
// a hardware sweep, and reads go through a RAM-style output pipeline.
//
// state      | meaning
// S_CLEAR    | sweep zeros into the table, one address per cycle
// S_IDLE     | ready for an update or a clear request
// S_RD_WAIT  | wait RD_LAT cycles for table read data
// S_CMP      | latch stored entry, compute candidate and changed
// S_WRITE    | conditional write-back, leader update, done pulse
// S_DONE_ERR | out-of-range id, done/err pulse visible
module leaderboard_tracker #(
  parameter int NUM_PLAYERS = 8,
  parameter int ID_W        = 3,
  parameter int SCORE_W     = 4,
  parameter int MODE        = 0,
  parameter int RD_LAT      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  leaderboard_tracker_if.slave   bus,
  output logic                   busy,
  output logic [SCORE_W-1:0]     max_score,
  output logic [ID_W-1:0]        max_id,
  output logic                   max_valid
);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_RD_WAIT, S_CMP, S_WRITE, S_DONE_ERR
  } state_t;

  localparam logic [ID_W-1:0] LAST_ADDR = ID_W'(NUM_PLAYERS - 1);

  state_t             state, state_next;
  logic [ID_W-1:0]    clr_addr;
  logic [ID_W-1:0]    id_q;
  logic [SCORE_W-1:0] score_q;
  logic [2:0]         wait_cnt;
  logic [SCORE_W-1:0] cand, cand_q;
  logic               changed, changed_q;
  logic [SCORE_W:0]   sum;
  logic               accept, clear_start;
  logic               done_next, err_next, best_next, nmax_next;
  logic               done_q, err_q, best_q, nmax_q;

  logic [SCORE_W-1:0] table_mem [NUM_PLAYERS];
  logic [SCORE_W-1:0] rd_pipe [RD_LAT];

  assign bus.upd_ready = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign bus.upd_done  = done_q;
  assign bus.upd_err   = err_q;
  assign bus.new_best  = best_q;
  assign bus.new_max   = nmax_q;

  always_comb begin
    sum     = {1'b0, rd_pipe[RD_LAT-1]} + {1'b0, score_q};
    cand    = rd_pipe[RD_LAT-1];
    changed = 1'b0;
    if (MODE == 0) begin
      changed = (score_q > rd_pipe[RD_LAT-1]);
      cand    = changed ? score_q : rd_pipe[RD_LAT-1];
    end else begin
      cand    = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
      changed = (cand != rd_pipe[RD_LAT-1]);
    end
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    clear_start = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    best_next   = 1'b0;
    nmax_next   = 1'b0;
    case (state)
      S_CLEAR:   if (clr_addr == LAST_ADDR) state_next = S_IDLE;
      S_IDLE: begin
        if (clr) begin
          clear_start = 1'b1;
          state_next  = S_CLEAR;
        end else if (bus.upd_valid) begin
          accept = 1'b1;
          // Bad ids complete immediately so the pulse lands right after acceptance.
          if (32'(bus.upd_id) >= 32'(NUM_PLAYERS)) begin
            state_next = S_DONE_ERR;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end else begin
            state_next = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: if (wait_cnt == 3'd0) state_next = S_CMP;
      S_CMP:     state_next = S_WRITE;
      S_WRITE: begin
        state_next = S_IDLE;
        done_next  = 1'b1;
        best_next  = changed_q;
        nmax_next  = (cand_q > max_score);
      end
      S_DONE_ERR: state_next = S_IDLE;
      default:    state_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_CLEAR;
      clr_addr  <= '0;
      id_q      <= '0;
      score_q   <= '0;
      wait_cnt  <= '0;
      cand_q    <= '0;
      changed_q <= 1'b0;
      max_score <= '0;
      max_id    <= '0;
      max_valid <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      best_q    <= 1'b0;
      nmax_q    <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= done_next;
      err_q  <= err_next;
      best_q <= best_next;
      nmax_q <= nmax_next;
      if (clear_start) begin
        clr_addr  <= '0;
        max_score <= '0;
        max_id    <= '0;
        max_valid <= 1'b0;
      end else if (state == S_CLEAR) begin
        clr_addr <= clr_addr + 1'b1;
      end
      if (accept) begin
        id_q     <= bus.upd_id;
        score_q  <= bus.upd_score;
        wait_cnt <= 3'(RD_LAT - 1);
      end else if (state == S_RD_WAIT && wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
      if (state == S_CMP) begin
        cand_q    <= cand;
        changed_q <= changed;
      end
      // Ties with the current leader keep the existing max_id.
      if (state == S_WRITE) begin
        if (cand_q > max_score) begin
          max_score <= cand_q;
          max_id    <= id_q;
        end
        if (cand_q != '0) max_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && state == S_CLEAR)
      table_mem[clr_addr] <= '0;
    else if (rst && state == S_WRITE && changed_q)
      table_mem[id_q] <= cand_q;
    rd_pipe[0] <= table_mem[id_q];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

endmodule

// File: tb/tb_leaderboard_tracker.sv
// Directed bench: best-of and accumulate instances plus a 5-player instance
// for bad ids, soft clear and clear/update collision.
module tb_leaderboard_tracker;
  logic clk = 1'b0;
  logic rst;
  logic clr0, clr1, clr2;
  logic busy0, busy1, busy2;
  logic [3:0] ms0, ms1, ms2;
  logic [2:0] mi0, mi1, mi2;
  logic mv0, mv1, mv2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  leaderboard_tracker_if #(.ID_W(3), .SCORE_W(4)) b0 ();
  leaderboard_tracker_if #(.ID_W(3), .SCORE_W(4)) b1 ();
  leaderboard_tracker_if #(.ID_W(3), .SCORE_W(4)) b2 ();

  leaderboard_tracker #(.NUM_PLAYERS(8), .ID_W(3), .SCORE_W(4), .MODE(0), .RD_LAT(2)) dut0 (
    .clk(clk), .rst(rst), .clr(clr0), .bus(b0.slave), .busy(busy0),
    .max_score(ms0), .max_id(mi0), .max_valid(mv0));
  leaderboard_tracker #(.NUM_PLAYERS(8), .ID_W(3), .SCORE_W(4), .MODE(1), .RD_LAT(2)) dut1 (
    .clk(clk), .rst(rst), .clr(clr1), .bus(b1.slave), .busy(busy1),
    .max_score(ms1), .max_id(mi1), .max_valid(mv1));
  leaderboard_tracker #(.NUM_PLAYERS(5), .ID_W(3), .SCORE_W(4), .MODE(0), .RD_LAT(1)) dut2 (
    .clk(clk), .rst(rst), .clr(clr2), .bus(b2.slave), .busy(busy2),
    .max_score(ms2), .max_id(mi2), .max_valid(mv2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [2:0] id, input logic [3:0] sc);
    case (d)
      0: begin b0.upd_valid = v; b0.upd_id = id; b0.upd_score = sc; end
      1: begin b1.upd_valid = v; b1.upd_id = id; b1.upd_score = sc; end
      default: begin b2.upd_valid = v; b2.upd_id = id; b2.upd_score = sc; end
    endcase
  endtask

  // {ready, done, err, new_best, new_max}
  function automatic logic [4:0] flags(input int d);
    case (d)
      0: return {b0.upd_ready, b0.upd_done, b0.upd_err, b0.new_best, b0.new_max};
      1: return {b1.upd_ready, b1.upd_done, b1.upd_err, b1.new_best, b1.new_max};
      default: return {b2.upd_ready, b2.upd_done, b2.upd_err, b2.new_best, b2.new_max};
    endcase
  endfunction

  task automatic upd_chk(input string tag, input int d, input logic [2:0] id, input logic [3:0] sc,
                         input int exp_lat, input logic ee, input logic eb, input logic em);
    logic [4:0] fl;
    int n;
    int lat;
    @(negedge clk);
    drive(d, 1'b1, id, sc);
    n = 0;
    fl = flags(d);
    while (!fl[4] && n < 30) begin
      @(negedge clk);
      n++;
      fl = flags(d);
    end
    chk({tag, "_accept"}, fl[4], 1);
    @(negedge clk);
    drive(d, 1'b0, 3'h7, 4'hF);
    lat = 1;
    fl = flags(d);
    while (!fl[3] && lat < 30) begin
      @(negedge clk);
      lat++;
      fl = flags(d);
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdy"}, fl[4], !ee);
    chk({tag, "_err"}, fl[2], ee);
    chk({tag, "_best"}, fl[1], eb);
    chk({tag, "_nmax"}, fl[0], em);
    @(negedge clk);
    fl = flags(d);
    chk({tag, "_pulse"}, fl[3:0], 0);
  endtask

  initial begin
    logic [4:0] fl;
    logic seen;
    rst = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    drive(0, 1'b0, 3'h0, 4'h0);
    drive(1, 1'b0, 3'h0, 4'h0);
    drive(2, 1'b0, 3'h0, 4'h0);
    repeat (2) @(negedge clk);
    fl = flags(0);
    chk("rst_busy", busy0, 1);
    chk("rst_flags", fl, 0);
    chk("rst_max", {mv0, mi0, ms0}, 0);
    rst = 1'b1;
    chk("clr_busy_0", busy0, 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("clr_busy_%0d", i), busy0, 1);
    end
    @(negedge clk);
    fl = flags(0);
    chk("clr_done_ready", fl[4], 1);
    chk("clr_done_busy", busy0, 0);
    chk("clr_done_max", {mv0, ms0}, 0);

    // best-of mode
    upd_chk("m0_a", 0, 3'd3, 4'd5, 5, 1'b0, 1'b1, 1'b1);
    chk("m0_a_max", {mv0, mi0, ms0}, {1'b1, 3'd3, 4'd5});
    upd_chk("m0_lower", 0, 3'd3, 4'd4, 5, 1'b0, 1'b0, 1'b0);
    chk("m0_lower_max", {mi0, ms0}, {3'd3, 4'd5});
    upd_chk("m0_tie", 0, 3'd3, 4'd5, 5, 1'b0, 1'b0, 1'b0);
    upd_chk("lt_1", 0, 3'd1, 4'd7, 5, 1'b0, 1'b1, 1'b1);
    chk("lt_1_max", {mi0, ms0}, {3'd1, 4'd7});
    upd_chk("lt_6", 0, 3'd6, 4'd7, 5, 1'b0, 1'b1, 1'b0);
    chk("lt_6_max", {mi0, ms0}, {3'd1, 4'd7});
    upd_chk("lt_6b", 0, 3'd6, 4'd9, 5, 1'b0, 1'b1, 1'b1);
    chk("lt_6b_max", {mi0, ms0}, {3'd6, 4'd9});

    // accumulate mode
    upd_chk("m1_a", 1, 3'd2, 4'd9, 5, 1'b0, 1'b1, 1'b1);
    chk("m1_a_max", {mi1, ms1}, {3'd2, 4'd9});
    upd_chk("m1_sat", 1, 3'd2, 4'd9, 5, 1'b0, 1'b1, 1'b1);
    chk("m1_sat_max", ms1, 15);
    upd_chk("m1_full", 1, 3'd2, 4'd3, 5, 1'b0, 1'b0, 1'b0);
    chk("m1_full_max", ms1, 15);

    // 5 players, read latency 1
    upd_chk("bad_id", 2, 3'd6, 4'd3, 1, 1'b1, 1'b0, 1'b0);
    chk("bad_id_max", {mv2, ms2}, 0);
    upd_chk("n5_a", 2, 3'd4, 4'd2, 4, 1'b0, 1'b1, 1'b1);
    chk("n5_a_max", {mv2, mi2, ms2}, {1'b1, 3'd4, 4'd2});
    @(negedge clk);
    clr2 = 1'b1;
    drive(2, 1'b1, 3'd1, 4'd9);
    @(negedge clk);
    clr2 = 1'b0;
    drive(2, 1'b0, 3'd0, 4'd0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("n5_clr_busy_%0d", i), busy2, 1);
      fl = flags(2);
      seen = seen | fl[3];
      @(negedge clk);
    end
    chk("n5_clr_idle", busy2, 0);
    chk("n5_clr_nodone", seen, 0);
    chk("n5_clr_max", {mv2, ms2}, 0);
    upd_chk("n5_re", 2, 3'd1, 4'd9, 4, 1'b0, 1'b1, 1'b1);
    upd_chk("n5_wiped", 2, 3'd4, 4'd1, 4, 1'b0, 1'b1, 1'b0);
    chk("n5_wiped_max", {mi2, ms2}, {3'd1, 4'd9});

    // reset during RD_WAIT
    @(negedge clk);
    drive(0, 1'b1, 3'd3, 4'd1);
    @(negedge clk);
    drive(0, 1'b0, 3'd0, 4'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      fl = flags(0);
      seen = seen | fl[3];
      @(negedge clk);
    end
    chk("mid_rst_nodone", seen, 0);
    chk("mid_rst_max", {mv0, ms0}, 0);
    upd_chk("mid_rst_post", 0, 3'd3, 4'd1, 5, 1'b0, 1'b1, 1'b1);
    chk("mid_rst_post_max", {mi0, ms0}, {3'd3, 4'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/leaderboard_tracker.md
Name: leaderboard_tracker

Overview:
Per-player score table with a running global leader, for the memory-game top level. Each game round posts (player ID, round score) through a valid/ready handshake. The block updates that player's stored entry, either best-of or saturating accumulate, and maintains the high score and the ID of the player who holds it for the 7-segment display path. It is parametrised in player count, score width, storage read latency and scoring mode, and it clears its table by hardware sweep on reset or on request.

Parameters:
NUM_PLAYERS, 8, number of table entries (2..16)
ID_W, 3, player ID width; 2^ID_W >= NUM_PLAYERS
SCORE_W, 4, score width in table and on all score ports
MODE, 0, 0 = keep best score per player; 1 = accumulate per player, saturating
RD_LAT, 2, table read latency in cycles (1..4); models the synchronous RAM output pipeline

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
clr  in  1  soft clear request; sampled in IDLE only
upd_valid  in  1  update request valid
upd_id  in  ID_W  player ID of the update
upd_score  in  SCORE_W  round score of the update
upd_ready  out  1  block can accept an update this cycle
upd_done  out  1  one-cycle pulse: the update has completed
upd_err  out  1  valid with upd_done; high when upd_id >= NUM_PLAYERS
new_best  out  1  valid with upd_done; high when the player's entry changed
new_max  out  1  valid with upd_done; high when the leader changed
busy  out  1  high in any state other than IDLE
max_score  out  SCORE_W  current high score
max_id  out  ID_W  player holding max_score
max_valid  out  1  high once any nonzero entry exists since the last clear

Behaviour:
- Reset: rst sampled low on any edge forces state CLEAR and clear address 0. Registered outputs after reset: max_score=0, max_id=0, max_valid=0, upd_ready=0, upd_done=0, upd_err=0, new_best=0, new_max=0, busy=1. A reset in the middle of an update abandons the update with no pulse.
- CLEAR state: writes 0 to address 0..NUM_PLAYERS-1, one address per cycle, so it lasts exactly NUM_PLAYERS cycles. It then goes to IDLE, where upd_ready=1 and busy=0.
- IDLE state:
  - clr=1 resets max_score, max_id and max_valid, then enters CLEAR.
  - clr and upd_valid high together: clr wins, and the update is not accepted.
  - upd_valid & upd_ready: latch id and score, drive the read address, then go to RD_WAIT. upd_ready drops on the next cycle.
- RD_WAIT state: holds for RD_LAT cycles, then goes to CMP.
- CMP state: latches the table output as stored and computes the candidate.
  - MODE 0: candidate = max(stored, score). changed = (score > stored). A tie does not write.
  - MODE 1: candidate = stored + score, computed at SCORE_W+1 bits and saturated to 2^SCORE_W-1. changed = (candidate != stored).
- WRITE state: writes the candidate only if changed.
  - If candidate > max_score: max_score <= candidate, max_id <= id, new_max=1.
  - On a tie with max_score, the existing leader is kept.
  - max_valid <= 1 when the candidate is nonzero.
  - Asserts upd_done for one cycle, with new_best=changed, then returns to IDLE.
- Latency: acceptance on edge k gives upd_done high in the cycle after edge k+RD_LAT+2. upd_ready is high in that same cycle, so back-to-back throughput is one update per RD_LAT+3 cycles.
- Invalid ID (upd_id >= NUM_PLAYERS):
  - The update is accepted.
  - There is no table access and the max is unchanged.
  - It goes IDLE -> DONE_ERR -> IDLE. upd_done=1 and upd_err=1 in the cycle after acceptance; new_best=0 and new_max=0.
- Updates are never dropped: upd_id and upd_score are ignored unless upd_valid & upd_ready on the same edge.
- upd_err, new_best and new_max are 0 whenever upd_done=0.

Test Plan:
- Reset with NUM_PLAYERS=8: rst low 2 cycles then high -> busy=1 for 8 cycles, then upd_ready=1, max_valid=0, max_score=0.
- MODE 0, RD_LAT 2: update (id 3, score 5) accepted at edge k -> done in the cycle after edge k+4 with new_best=1, new_max=1, max_score=5, max_id=3. Then (3, 4) -> new_best=0, max unchanged. Then (3, 5) -> tie, new_best=0.
- Leader tie: (1, 7) then (6, 7) -> second gives new_best=1, new_max=0, max_id stays 1. Then (6, 9) -> max_id=6, max_score=9.
- MODE 1, SCORE_W=4: (2, 9) then (2, 9) -> entry saturates at 15, max_score=15. Then (2, 3) -> new_best=0.
- Invalid ID: NUM_PLAYERS=5, upd_id=6 -> done and err in the cycle after acceptance, max unchanged. Separately, clr and upd_valid high together in IDLE -> clear wins, busy for 5 cycles, max_valid=0, and the update is later accepted only when re-presented.
- Reset mid-operation: rst low during RD_WAIT -> no upd_done, CLEAR restarts, and all table entries read back 0 in later updates (e.g. (3, 1) gives new_best=1).
